// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd - hundredth-second stopwatch with BCD display output.
//
// Buttons are synchronised, debounced against the 1 ms strobe and turned
// into single-clock press pulses.  A three-state controller (IDLE/RUN/STOP)
// gates a ms divider that advances a four-digit BCD count (SS.hh).  The
// count saturates at 99.99 and forces STOP.
//
// Optional feature: define STOPWATCH_LAP_EN to build the lap (display
// freeze) function.  Without it btn_lap is ignored and dat always shows
// the live count.
//
// Parameters:
//   DEB_MS  - debounce interval, in ce1ms strobes
//   TICK_MS - ce1ms strobes per hundredth-second count
// Ports:
//   clk     - system clock
//   rst     - synchronous active-high reset
//   ce1ms   - one-clk strobe every 1 ms
//   btn_ss  - raw start/stop button (async, active high)
//   btn_clr - raw clear button (async, active high)
//   btn_lap - raw lap button (async, active high)
//   dat     - BCD digits {S10,S1,h10,h1}, registered
//   set_P   - high exactly while running, registered
module stopwatch_bcd #(
    parameter int DEB_MS  = 20,
    parameter int TICK_MS = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ce1ms,
    input  logic        btn_ss,
    input  logic        btn_clr,
    input  logic        btn_lap,
    output logic [15:0] dat,
    output logic        set_P
);

`ifdef STOPWATCH_LAP_EN
    localparam int NB = 3;
`else
    localparam int NB = 2;
`endif

    localparam int CNT_W = (DEB_MS > 1) ? $clog2(DEB_MS) : 1;
    localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_MS - 1);

    localparam int DIV_W = (TICK_MS > 1) ? $clog2(TICK_MS) : 1;
    localparam logic [DIV_W-1:0] DIV_ZERO = DIV_W'(0);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_MS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_STOP = 2'd2
    } state_t;

    // Increment a four-digit BCD value, rippling the carry h1 -> S10.
    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        carry;
        r     = v;
        carry = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (carry) begin
                if (r[4*i +: 4] == 4'd9) begin
                    r[4*i +: 4] = 4'd0;
                    carry       = 1'b1;
                end else begin
                    r[4*i +: 4] = r[4*i +: 4] + 4'd1;
                    carry       = 1'b0;
                end
            end else begin
                carry = 1'b0;
            end
        end
        return r;
    endfunction

    // ------------------------------------------------------------------
    // Button conditioning: bit 0 = ss, bit 1 = clr, bit 2 = lap (if built)
    // ------------------------------------------------------------------
    logic [NB-1:0]    btn_raw_s;
    logic [NB-1:0]    sync1_r;
    logic [NB-1:0]    sync2_r;
    logic [NB-1:0]    level_r;
    logic [NB-1:0]    level_nxt_s;
    logic [NB-1:0]    press_r;
    logic [CNT_W-1:0] deb_cnt_r     [NB];
    logic [CNT_W-1:0] deb_cnt_nxt_s [NB];

`ifdef STOPWATCH_LAP_EN
    assign btn_raw_s = {btn_lap, btn_clr, btn_ss};
`else
    assign btn_raw_s = {btn_clr, btn_ss};
`endif

    // Debounce: the level flips only after DEB_MS consecutive strobes on
    // which the synchronised input disagrees; any agreement restarts it.
    always_comb begin
        for (int i = 0; i < NB; i++) begin
            level_nxt_s[i]   = level_r[i];
            deb_cnt_nxt_s[i] = deb_cnt_r[i];
            if (sync2_r[i] == level_r[i]) begin
                deb_cnt_nxt_s[i] = CNT_ZERO;
            end else if (ce1ms) begin
                if (deb_cnt_r[i] == CNT_LAST) begin
                    level_nxt_s[i]   = sync2_r[i];
                    deb_cnt_nxt_s[i] = CNT_ZERO;
                end else begin
                    deb_cnt_nxt_s[i] = deb_cnt_r[i] + CNT_ONE;
                end
            end else begin
                deb_cnt_nxt_s[i] = deb_cnt_r[i];
            end
        end
    end

    // Synchroniser, debounce state and one-clock press pulse on 0->1.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r <= {NB{1'b0}};
            sync2_r <= {NB{1'b0}};
            level_r <= {NB{1'b0}};
            press_r <= {NB{1'b0}};
            for (int i = 0; i < NB; i++) begin
                deb_cnt_r[i] <= CNT_ZERO;
            end
        end else begin
            sync1_r <= btn_raw_s;
            sync2_r <= sync1_r;
            level_r <= level_nxt_s;
            press_r <= level_nxt_s & ~level_r;
            for (int i = 0; i < NB; i++) begin
                deb_cnt_r[i] <= deb_cnt_nxt_s[i];
            end
        end
    end

    logic ss_press_s;
    logic clr_press_s;
    assign ss_press_s  = press_r[0];
    assign clr_press_s = press_r[1];

    // ------------------------------------------------------------------
    // Controller, divider and BCD count
    // ------------------------------------------------------------------
    state_t           state_r;
    state_t           state_nxt_s;
    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_nxt_s;
    logic [15:0]      count_r;
    logic [15:0]      count_nxt_s;
    logic             tick_s;
    logic [15:0]      dat_r;
    logic [15:0]      dat_nxt_s;
    logic             set_p_r;

    // Next state, divider and count.  A ss press takes priority over clr,
    // so a simultaneous clr is simply dropped.
    always_comb begin
        state_nxt_s = state_r;
        div_nxt_s   = div_r;
        count_nxt_s = count_r;
        tick_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (ss_press_s) begin
                    state_nxt_s = ST_RUN;
                    div_nxt_s   = DIV_ZERO;
                    count_nxt_s = 16'h0000;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (ce1ms) begin
                    if (div_r == DIV_LAST) begin
                        div_nxt_s = DIV_ZERO;
                        tick_s    = 1'b1;
                    end else begin
                        div_nxt_s = div_r + DIV_ONE;
                    end
                end else begin
                    div_nxt_s = div_r;
                end
                // Saturate at 99.99 instead of wrapping.
                if (tick_s) begin
                    if (count_r == 16'h9999) begin
                        state_nxt_s = ST_STOP;
                    end else begin
                        count_nxt_s = bcd_inc(count_r);
                    end
                end else begin
                    count_nxt_s = count_r;
                end
                if (ss_press_s) begin
                    state_nxt_s = ST_STOP;
                end else begin
                    state_nxt_s = (state_nxt_s == ST_STOP) ? ST_STOP : ST_RUN;
                end
            end
            ST_STOP: begin
                if (ss_press_s) begin
                    state_nxt_s = ST_RUN;
                end else if (clr_press_s) begin
                    state_nxt_s = ST_IDLE;
                    div_nxt_s   = DIV_ZERO;
                    count_nxt_s = 16'h0000;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                div_nxt_s   = DIV_ZERO;
                count_nxt_s = 16'h0000;
            end
        endcase
    end

`ifdef STOPWATCH_LAP_EN
    logic lap_press_s;
    logic freeze_r;
    logic freeze_nxt_s;
    assign lap_press_s = press_r[2];

    // Freeze control: toggles on lap in RUN, lap elsewhere only releases,
    // and an effective clear in STOP always releases.
    always_comb begin
        freeze_nxt_s = freeze_r;
        if ((state_r == ST_STOP) && clr_press_s && !ss_press_s) begin
            freeze_nxt_s = 1'b0;
        end else if (lap_press_s) begin
            if (state_r == ST_RUN) begin
                freeze_nxt_s = ~freeze_r;
            end else begin
                freeze_nxt_s = 1'b0;
            end
        end else begin
            freeze_nxt_s = freeze_r;
        end
    end

    // Freeze flag register.
    always_ff @(posedge clk) begin
        if (rst) begin
            freeze_r <= 1'b0;
        end else begin
            freeze_r <= freeze_nxt_s;
        end
    end

    // While frozen the display keeps its last value.
    assign dat_nxt_s = freeze_nxt_s ? dat_r : count_nxt_s;
`else
    logic unused_lap_s;
    assign unused_lap_s = btn_lap;
    assign dat_nxt_s    = count_nxt_s;
`endif

    // State, divider, count and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
            div_r   <= DIV_ZERO;
            count_r <= 16'h0000;
            dat_r   <= 16'h0000;
            set_p_r <= 1'b0;
        end else begin
            state_r <= state_nxt_s;
            div_r   <= div_nxt_s;
            count_r <= count_nxt_s;
            dat_r   <= dat_nxt_s;
            set_p_r <= (state_nxt_s == ST_RUN);
        end
    end

    assign dat   = dat_r;
    assign set_P = set_p_r;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Directed testbench for stopwatch_bcd with a small behavioural model and an
// expected-value queue.  A second instance with TICK_MS=1 and a continuous
// strobe reaches the 99.99 saturation point in a short run.
module tb_stopwatch_bcd;

    localparam int DEB_MS  = 2;
    localparam int TICK_MS = 10;
    localparam int CE_DIV  = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        ce1ms;
    logic        btn_ss;
    logic        btn_clr;
    logic        btn_lap;
    logic [15:0] dat;
    logic        set_P;

    logic        ce2;
    logic        ss2;
    logic        clr2;
    logic        lap2;
    logic [15:0] dat2;
    logic        setp2;

    always #10 clk = ~clk;

    stopwatch_bcd #(.DEB_MS(DEB_MS), .TICK_MS(TICK_MS)) dut (
        .clk     (clk),
        .rst     (rst),
        .ce1ms   (ce1ms),
        .btn_ss  (btn_ss),
        .btn_clr (btn_clr),
        .btn_lap (btn_lap),
        .dat     (dat),
        .set_P   (set_P)
    );

    stopwatch_bcd #(.DEB_MS(DEB_MS), .TICK_MS(1)) dut_sat (
        .clk     (clk),
        .rst     (rst),
        .ce1ms   (ce2),
        .btn_ss  (ss2),
        .btn_clr (clr2),
        .btn_lap (lap2),
        .dat     (dat2),
        .set_P   (setp2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    string       tag_q[$];
    logic [16:0] exp_q[$];

    typedef enum int {M_IDLE, M_RUN, M_STOP} mstate_t;
    mstate_t     m_state;
    int          m_ms;
    logic        m_freeze;
    logic [15:0] m_frozen;

    function automatic logic [15:0] to_bcd(input int v);
        logic [15:0] r;
        r[15:12] = 4'((v / 1000) % 10);
        r[11:8]  = 4'((v / 100) % 10);
        r[7:4]   = 4'((v / 10) % 10);
        r[3:0]   = 4'(v % 10);
        return r;
    endfunction

    function automatic logic bcd_ok(input logic [15:0] v);
        logic [15:0] t;
        t = v;
        return (t[15:12] <= 4'd9) && (t[11:8] <= 4'd9) &&
               (t[7:4] <= 4'd9) && (t[3:0] <= 4'd9);
    endfunction

    function automatic logic [15:0] model_dat();
        int c;
        c = m_ms / 10;
        if (c > 9999) c = 9999;
        return m_freeze ? m_frozen : to_bcd(c);
    endfunction

    task automatic push_exp(input string tag, input logic [15:0] d, input logic p);
        tag_q.push_back(tag);
        exp_q.push_back({p, d});
    endtask

    task automatic check_out(input logic [15:0] obs_d, input logic obs_p);
        string       t;
        logic [16:0] e;
        t = tag_q.pop_front();
        e = exp_q.pop_front();
        n_assert++;
        assert (obs_d === e[15:0]) else begin
            n_fail++;
            $error("FAIL %s dat: got %h expected %h", t, obs_d, e[15:0]);
        end
        n_assert++;
        assert (obs_p === e[16]) else begin
            n_fail++;
            $error("FAIL %s set_P: got %b expected %b", t, obs_p, e[16]);
        end
    endtask

    task automatic expect_const(input string tag, input logic [15:0] d, input logic p);
        push_exp(tag, d, p);
        check_out(dat, set_P);
    endtask

    task automatic expect_model(input string tag);
        push_exp(tag, model_dat(), m_state == M_RUN);
        check_out(dat, set_P);
    endtask

    task automatic step_ms(input int n);
        repeat (n) begin
            @(negedge clk);
            ce1ms = 1'b1;
            @(negedge clk);
            ce1ms = 1'b0;
            repeat (CE_DIV - 2) @(negedge clk);
        end
    endtask

    task automatic run(input int n);
        step_ms(n);
        if (m_state == M_RUN) m_ms += n;
    endtask

    task automatic model_press(input logic ss, input logic clr, input logic lap);
`ifdef STOPWATCH_LAP_EN
        if (lap) begin
            if (m_state == M_RUN) begin
                if (!m_freeze) m_frozen = model_dat();
                m_freeze = !m_freeze;
            end else begin
                m_freeze = 1'b0;
            end
        end
`endif
        if (ss) begin
            case (m_state)
                M_IDLE: begin m_state = M_RUN; m_ms = 0; end
                M_RUN:  m_state = M_STOP;
                default: m_state = M_RUN;
            endcase
        end else if (clr && m_state == M_STOP) begin
            m_state  = M_IDLE;
            m_ms     = 0;
            m_freeze = 1'b0;
        end
    endtask

    // Hold the buttons for 3 strobes (press lands after the third), then
    // release for 3 strobes so the debouncer settles low again.
    task automatic press(input logic ss, input logic clr, input logic lap);
        btn_ss  = ss;
        btn_clr = clr;
        btn_lap = lap;
        run(3);
        model_press(ss, clr, lap);
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        btn_lap = 1'b0;
        run(3);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst      = 1'b0;
        m_state  = M_IDLE;
        m_ms     = 0;
        m_freeze = 1'b0;
        m_frozen = 16'h0000;
    endtask

    initial begin
        logic found;
        logic bad;
        rst = 1'b1; ce1ms = 1'b0; btn_ss = 1'b0; btn_clr = 1'b0; btn_lap = 1'b0;
        ce2 = 1'b0; ss2 = 1'b0; clr2 = 1'b0; lap2 = 1'b0;
        @(negedge clk);
        do_reset();
        expect_const("reset", 16'h0000, 1'b0);

        run(100);
        expect_const("idle_100ms", 16'h0000, 1'b0);

        // Glitch shorter than the debounce interval.
        btn_ss = 1'b1;
        run(1);
        btn_ss = 1'b0;
        run(3);
        expect_model("short_ss");
        expect_const("short_ss_const", 16'h0000, 1'b0);

        press(1'b1, 1'b0, 1'b0);
        expect_model("start");
        expect_const("start_const", 16'h0000, 1'b1);

        run(1224);
        press(1'b1, 1'b0, 1'b0);
        expect_const("stop_0123", 16'h0123, 1'b0);
        expect_model("stop_model");

        // Resume: the held divider must finish before the next tick.
        press(1'b1, 1'b0, 1'b0);
        run(5);
        expect_const("resume_div_held", 16'h0123, 1'b1);
        run(1);
        expect_model("resume_div_9");
        @(negedge clk);
        ce1ms = 1'b1;
        expect_const("tick_pre_edge", 16'h0123, 1'b1);
        @(negedge clk);
        ce1ms = 1'b0;
        m_ms++;
        expect_const("tick_latency", 16'h0124, 1'b1);
        repeat (CE_DIV - 2) @(negedge clk);

        press(1'b0, 1'b1, 1'b0);
        expect_model("clr_in_run");

        press(1'b1, 1'b0, 1'b0);
        expect_model("stop_again");

        press(1'b1, 1'b1, 1'b0);
        expect_model("ss_clr_same_clk");
        expect_const("ss_clr_const", 16'h0125, 1'b1);

        press(1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b1, 1'b0);
        expect_const("clr_in_stop", 16'h0000, 1'b0);

        // Reset in RUN while a ss press is being debounced.
        press(1'b1, 1'b0, 1'b0);
        run(50);
        btn_ss = 1'b1;
        run(2);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        btn_ss = 1'b0;
        do_reset();
        run(5);
        expect_const("rst_mid_run", 16'h0000, 1'b0);

        // Lap freeze / release (ignored when the feature is not built).
        press(1'b1, 1'b0, 1'b0);
        run(494);
        press(1'b0, 1'b0, 1'b1);
        expect_const("lap_at_0050", 16'h0050, 1'b1);
        run(294);
`ifdef STOPWATCH_LAP_EN
        expect_const("lap_hold", 16'h0050, 1'b1);
`else
        expect_const("lap_ignored", 16'h0079, 1'b1);
`endif
        press(1'b0, 1'b0, 1'b1);
        expect_const("lap_release", 16'h0080, 1'b1);
        press(1'b0, 1'b0, 1'b1);
        press(1'b1, 1'b0, 1'b0);
        expect_model("lap_across_stop");
        press(1'b0, 1'b1, 1'b0);
        expect_model("lap_clr");

        // Saturation at 99.99 on the fast instance.
        ce2 = 1'b1;
        ss2 = 1'b1;
        repeat (6) @(negedge clk);
        ss2   = 1'b0;
        found = 1'b0;
        bad   = 1'b0;
        for (int i = 0; i < 12000 && !found; i++) begin
            @(negedge clk);
            if (!bcd_ok(dat2)) bad = 1'b1;
            if (dat2 == 16'h9998) found = 1'b1;
        end
        n_assert++;
        assert (found === 1'b1) else begin
            n_fail++;
            $error("FAIL sat_reach_9998: got timeout expected 9998 within bound");
        end
        push_exp("sat_9998", 16'h9998, 1'b1);
        check_out(dat2, setp2);
        repeat (20) begin
            @(negedge clk);
            if (!bcd_ok(dat2)) bad = 1'b1;
        end
        push_exp("sat_hold", 16'h9999, 1'b0);
        check_out(dat2, setp2);
        n_assert++;
        assert (bad === 1'b0) else begin
            n_fail++;
            $error("FAIL sat_bcd_nibbles: got non-BCD nibble expected none");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
